br_fifo_ctrl_1r1w_push_credit_multiflow: RTL and testbench

- Multi-flow (virtual-channel) FIFO controller: NumFlows independent logical FIFOs statically partitioned in one external 1R1W RAM.
- Single credit/valid push port tagged with a flow id; per-flow credit return.
- Single ready/valid pop port with round-robin arbitration across non-empty flows.
- Sits at credit-based link receivers where several traffic classes share storage but must not block each other.

---
 rtl/br_fifo_ctrl_1r1w_push_credit_multiflow.sv | 230 +++++++++++++++++++++++
 tb/tb_br_fifo_ctrl_1r1w_push_credit_multiflow.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_fifo_ctrl_1r1w_push_credit_multiflow.sv
// ---------------------------------------------------------------------------
// br_fifo_ctrl_1r1w_push_credit_multiflow
//
// Controller for NumFlows independent logical FIFOs that share one external
// 1R1W RAM. Flow f owns RAM addresses f*Depth .. f*Depth+Depth-1. There is one
// credit/valid push port tagged with a flow id and one ready/valid pop port.
// The pop port picks among non-empty flows in round-robin order. Each flow
// keeps its own receiver credit counter, and that counter releases
// push_credit pulses to the sender.
//
// Optional build macro: BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
//   When it is defined, a push to a full flow is dropped and a sticky
//   overflow_err bit is raised for that flow.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   push_credit_stall           blocks every credit release
//   push_credit[NumFlows]       per-flow credit return pulse
//   push_valid/flow/data        push strobe, target flow, payload
//   pop_ready/valid/flow/data   pop handshake, granted flow, payload
//   full/empty[NumFlows]        registered per-flow status flags
//   items/slots                 registered per-flow occupancy / free space
//   credit_initial_push         per-flow credits loaded while rst is high
//   credit_withhold_push        per-flow credits held back from release
//   credit_count_push           per-flow credits held by the receiver
//   ram_wr_*                    RAM write port (write latency 1 cycle)
//   ram_rd_*                    RAM read port (read latency 0 cycles)
//   overflow_err[NumFlows]      sticky overflow flags (macro builds only)
// ---------------------------------------------------------------------------
module br_fifo_ctrl_1r1w_push_credit_multiflow #(
    parameter int NumFlows           = 2,
    parameter int Depth              = 2,
    parameter int BitWidth           = 1,
    parameter int MaxCredit          = Depth,
    parameter int RegisterPushCredit = 0,
    localparam int FlowIdWidth = ($clog2(NumFlows) > 1) ? $clog2(NumFlows) : 1,
    localparam int AddrWidth   = $clog2(NumFlows * Depth),
    localparam int CountWidth  = $clog2(Depth + 1),
    localparam int CreditWidth = $clog2(MaxCredit + 1),
    localparam int PtrWidth    = ($clog2(Depth) > 1) ? $clog2(Depth) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push_credit_stall,
    output logic [NumFlows-1:0]             push_credit,
    input  logic                            push_valid,
    input  logic [FlowIdWidth-1:0]          push_flow,
    input  logic [BitWidth-1:0]             push_data,
    input  logic                            pop_ready,
    output logic                            pop_valid,
    output logic [FlowIdWidth-1:0]          pop_flow,
    output logic [BitWidth-1:0]             pop_data,
    output logic [NumFlows-1:0]             full,
    output logic [NumFlows-1:0]             empty,
    output logic [NumFlows*CountWidth-1:0]  items,
    output logic [NumFlows*CountWidth-1:0]  slots,
    input  logic [NumFlows*CreditWidth-1:0] credit_initial_push,
    input  logic [NumFlows*CreditWidth-1:0] credit_withhold_push,
    output logic [NumFlows*CreditWidth-1:0] credit_count_push,
`ifdef BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
    output logic [NumFlows-1:0]             overflow_err,
`endif
    output logic                            ram_wr_valid,
    output logic [AddrWidth-1:0]            ram_wr_addr,
    output logic [BitWidth-1:0]             ram_wr_data,
    output logic                            ram_rd_addr_valid,
    output logic [AddrWidth-1:0]            ram_rd_addr,
    input  logic                            ram_rd_data_valid,
    input  logic [BitWidth-1:0]             ram_rd_data
);

    logic [PtrWidth-1:0]    w_wr_ptr [NumFlows];
    logic [PtrWidth-1:0]    w_rd_ptr [NumFlows];
    logic [NumFlows-1:0]    w_cand;
    logic [FlowIdWidth-1:0] w_rr_grant;
    logic [FlowIdWidth-1:0] w_grant;
    logic                   w_found;
    logic                   w_pop;
    logic                   w_push_ok;

    logic [FlowIdWidth-1:0] r_last;
    logic                   r_locked;
    logic [FlowIdWidth-1:0] r_lock_flow;

    // Search starts at the flow just after the last grant. Because r_last
    // resets to NumFlows-1, flow 0 is the first one considered.
    always_comb begin
        w_rr_grant = '0;
        w_found    = 1'b0;
        for (int i = 1; i <= NumFlows; i++) begin
            if (!w_found && w_cand[(int'(r_last) + i) % NumFlows]) begin
                w_rr_grant = FlowIdWidth'((int'(r_last) + i) % NumFlows);
                w_found    = 1'b1;
            end
        end
    end

    // A stalled grant stays locked, so pop_flow and pop_data hold until the
    // consumer accepts them, even if a higher-priority flow fills meanwhile.
    assign w_grant   = r_locked ? r_lock_flow : w_rr_grant;
    assign pop_valid = |w_cand;
    assign pop_flow  = w_grant;
    assign pop_data  = ram_rd_data;
    assign w_pop     = pop_valid & pop_ready;

    assign ram_rd_addr_valid = pop_valid;
    assign ram_rd_addr = AddrWidth'(int'(w_grant) * Depth + int'(w_rd_ptr[w_grant]));

`ifdef BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
    assign w_push_ok = push_valid & ~full[push_flow];
`else
    assign w_push_ok = push_valid;
`endif
    assign ram_wr_valid = w_push_ok;
    assign ram_wr_addr  = AddrWidth'(int'(push_flow) * Depth + int'(w_wr_ptr[push_flow]));
    assign ram_wr_data  = push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= FlowIdWidth'(NumFlows - 1);
            r_locked    <= 1'b0;
            r_lock_flow <= '0;
        end else begin
            r_locked    <= pop_valid & ~pop_ready;
            r_lock_flow <= w_grant;
            if (w_pop) r_last <= w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (ram_rd_data_valid == ram_rd_addr_valid);
            assert (!push_valid || (int'(push_flow) < NumFlows));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NumFlows; gi++) begin : gen_flow
            logic                   w_push_f;
            logic                   w_pop_f;
            logic                   w_cred;
            logic [CountWidth-1:0]  w_items_next;
            logic [CreditWidth-1:0] w_withhold;
            logic [PtrWidth-1:0]    r_wr_ptr;
            logic [PtrWidth-1:0]    r_rd_ptr;
            logic [CountWidth-1:0]  r_items;
            logic [CountWidth-1:0]  r_slots;
            logic                   r_full;
            logic                   r_empty;
            logic [CreditWidth-1:0] r_cnt;

            assign w_push_f   = w_push_ok & (push_flow == FlowIdWidth'(gi));
            assign w_pop_f    = w_pop & (w_grant == FlowIdWidth'(gi));
            assign w_withhold = credit_withhold_push[gi*CreditWidth +: CreditWidth];
            assign w_cred     = ~rst & ~push_credit_stall & (r_cnt > w_withhold);

            always_comb begin
                w_items_next = r_items;
                if (w_push_f && !w_pop_f) w_items_next = r_items + CountWidth'(1);
                if (!w_push_f && w_pop_f) w_items_next = r_items - CountWidth'(1);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_items  <= '0;
                    r_slots  <= CountWidth'(Depth);
                    r_full   <= 1'b0;
                    r_empty  <= 1'b1;
                    r_cnt    <= credit_initial_push[gi*CreditWidth +: CreditWidth];
                end else begin
                    // Explicit wrap at Depth-1 supports non-power-of-2 depths.
                    if (w_push_f)
                        r_wr_ptr <= (r_wr_ptr == PtrWidth'(Depth - 1)) ? '0 : r_wr_ptr + PtrWidth'(1);
                    if (w_pop_f)
                        r_rd_ptr <= (r_rd_ptr == PtrWidth'(Depth - 1)) ? '0 : r_rd_ptr + PtrWidth'(1);
                    r_items <= w_items_next;
                    r_slots <= CountWidth'(Depth) - w_items_next;
                    r_full  <= (w_items_next == CountWidth'(Depth));
                    r_empty <= (w_items_next == '0);
                    // A popped entry returns a credit, and a release spends one.
                    r_cnt   <= r_cnt + CreditWidth'(w_pop_f) - CreditWidth'(w_cred);
                end
            end

            if (RegisterPushCredit != 0) begin : gen_reg_credit
                logic r_credit_q;
                always_ff @(posedge clk) begin
                    if (rst) r_credit_q <= 1'b0;
                    else     r_credit_q <= w_cred;
                end
                assign push_credit[gi] = r_credit_q;
            end else begin : gen_comb_credit
                assign push_credit[gi] = w_cred;
            end

`ifdef BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
            logic r_ovf;
            always_ff @(posedge clk) begin
                if (rst) r_ovf <= 1'b0;
                else if (push_valid && (push_flow == FlowIdWidth'(gi)) && r_full) r_ovf <= 1'b1;
            end
            assign overflow_err[gi] = r_ovf;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    assert (credit_initial_push[gi*CreditWidth +: CreditWidth] <= CreditWidth'(Depth));
                end else begin
                    assert (r_cnt <= CreditWidth'(MaxCredit));
`ifndef BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
                    assert (!(push_valid && (push_flow == FlowIdWidth'(gi)) && r_full));
`endif
                end
            end

            assign w_wr_ptr[gi] = r_wr_ptr;
            assign w_rd_ptr[gi] = r_rd_ptr;
            assign w_cand[gi]   = (r_items != '0);
            assign full[gi]     = r_full;
            assign empty[gi]    = r_empty;
            assign items[gi*CountWidth +: CountWidth] = r_items;
            assign slots[gi*CountWidth +: CountWidth] = r_slots;
            assign credit_count_push[gi*CreditWidth +: CreditWidth] = r_cnt;
        end
    endgenerate

endmodule

// File: tb/tb_br_fifo_ctrl_1r1w_push_credit_multiflow.sv
// ---------------------------------------------------------------------------
// Testbench for br_fifo_ctrl_1r1w_push_credit_multiflow.
// Instance u_dut has 2 flows, Depth 4 and 8-bit data. It is checked every
// cycle against a per-flow scoreboard that also models round-robin order,
// grant locking and credits.
// Instance u_dut3 has 2 flows and Depth 3. It exercises pointer wrap at a
// non-power-of-2 depth and the push_credit_stall behaviour.
// ---------------------------------------------------------------------------
module tb_br_fifo_ctrl_1r1w_push_credit_multiflow;
    localparam int NF = 2, D = 4, CW = 3, CRW = 3, AW = 3;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    // Depth-4 instance signals.
    logic          push_credit_stall = 1'b0;
    logic [1:0]    push_credit;
    logic          push_valid = 1'b0;
    logic          push_flow = 1'b0;
    logic [7:0]    push_data = '0;
    logic          pop_ready = 1'b0;
    logic          pop_valid, pop_flow;
    logic [7:0]    pop_data;
    logic [1:0]    full, empty;
    logic [5:0]    items, slots;
    logic [5:0]    credit_initial_push = {3'd4, 3'd4};
    logic [5:0]    credit_withhold_push = '0;
    logic [5:0]    credit_count_push;
    logic          ram_wr_valid, ram_rd_addr_valid, ram_rd_data_valid;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [7:0]    ram_wr_data, ram_rd_data;
    logic [7:0]    mem_a [8];
`ifdef BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
    logic [1:0]    overflow_err;
    logic [1:0]    b_ovf;
`endif

    // Depth-3 instance signals.
    logic          b_stall = 1'b0;
    logic [1:0]    b_push_credit;
    logic          b_push_valid = 1'b0;
    logic          b_push_flow = 1'b0;
    logic [7:0]    b_push_data = '0;
    logic          b_pop_ready = 1'b0;
    logic          b_pop_valid, b_pop_flow;
    logic [7:0]    b_pop_data;
    logic [1:0]    b_full, b_empty;
    logic [3:0]    b_items, b_slots, b_ccount;
    logic [3:0]    b_init = '0, b_withhold = '0;
    logic          b_wr_valid, b_rd_av, b_rd_dv;
    logic [2:0]    b_wr_addr, b_rd_addr;
    logic [7:0]    b_wr_data, b_rd_data;
    logic [7:0]    mem_b [8];

    br_fifo_ctrl_1r1w_push_credit_multiflow #(
        .NumFlows(2), .Depth(4), .BitWidth(8), .MaxCredit(4), .RegisterPushCredit(0)
    ) u_dut (
        .clk(clk), .rst(rst), .push_credit_stall(push_credit_stall), .push_credit(push_credit),
        .push_valid(push_valid), .push_flow(push_flow), .push_data(push_data),
        .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_flow(pop_flow), .pop_data(pop_data),
        .full(full), .empty(empty), .items(items), .slots(slots),
        .credit_initial_push(credit_initial_push), .credit_withhold_push(credit_withhold_push),
        .credit_count_push(credit_count_push),
`ifdef BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
        .overflow_err(overflow_err),
`endif
        .ram_wr_valid(ram_wr_valid), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr_valid(ram_rd_addr_valid), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data_valid(ram_rd_data_valid), .ram_rd_data(ram_rd_data)
    );

    br_fifo_ctrl_1r1w_push_credit_multiflow #(
        .NumFlows(2), .Depth(3), .BitWidth(8), .MaxCredit(3), .RegisterPushCredit(0)
    ) u_dut3 (
        .clk(clk), .rst(rst), .push_credit_stall(b_stall), .push_credit(b_push_credit),
        .push_valid(b_push_valid), .push_flow(b_push_flow), .push_data(b_push_data),
        .pop_ready(b_pop_ready), .pop_valid(b_pop_valid), .pop_flow(b_pop_flow), .pop_data(b_pop_data),
        .full(b_full), .empty(b_empty), .items(b_items), .slots(b_slots),
        .credit_initial_push(b_init), .credit_withhold_push(b_withhold),
        .credit_count_push(b_ccount),
`ifdef BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
        .overflow_err(b_ovf),
`endif
        .ram_wr_valid(b_wr_valid), .ram_wr_addr(b_wr_addr), .ram_wr_data(b_wr_data),
        .ram_rd_addr_valid(b_rd_av), .ram_rd_addr(b_rd_addr),
        .ram_rd_data_valid(b_rd_dv), .ram_rd_data(b_rd_data)
    );

    // External RAMs: one-cycle write, combinational read.
    always @(posedge clk) if (ram_wr_valid) mem_a[ram_wr_addr] <= ram_wr_data;
    assign ram_rd_data       = mem_a[ram_rd_addr];
    assign ram_rd_data_valid = ram_rd_addr_valid;
    always @(posedge clk) if (b_wr_valid) mem_b[b_wr_addr] <= b_wr_data;
    assign b_rd_data = mem_b[b_rd_addr];
    assign b_rd_dv   = b_rd_av;

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and reference model for u_dut.
    logic [7:0] mq [NF][$];
    int m_wr [NF], m_rd [NF], m_cnt [NF], snd_cred [NF];
    bit m_ovf [NF];
    int m_last, m_lock_flow;
    bit m_locked;

    always @(negedge clk) begin : mon_a
        logic [NF-1:0]    e_empty, e_full, e_cred;
        logic [NF*CW-1:0] e_items, e_slots;
        logic [5:0]       e_cc;
        int g, fp;
        bit any;
        if (rst) begin
            for (int f = 0; f < NF; f++) begin
                mq[f].delete();
                m_wr[f] = 0; m_rd[f] = 0; m_cnt[f] = 4; m_ovf[f] = 0; snd_cred[f] = 0;
            end
            m_last = NF - 1; m_locked = 0; m_lock_flow = 0;
            check("rst_credit", push_credit, 0);
        end else begin
            for (int f = 0; f < NF; f++) begin
                e_empty[f] = (mq[f].size() == 0);
                e_full[f]  = (mq[f].size() == D);
                e_items[f*CW +: CW] = CW'(mq[f].size());
                e_slots[f*CW +: CW] = CW'(D - mq[f].size());
                e_cc[f*CRW +: CRW]  = CRW'(m_cnt[f]);
                e_cred[f] = !push_credit_stall &&
                            (m_cnt[f] > int'(credit_withhold_push[f*CRW +: CRW]));
            end
            check("empty", empty, e_empty);
            check("full", full, e_full);
            check("items", items, e_items);
            check("slots", slots, e_slots);
            check("push_credit", push_credit, e_cred);
            check("credit_count", credit_count_push, e_cc);

            any = 0; g = 0;
            if (m_locked) begin
                any = 1; g = m_lock_flow;
            end else begin
                for (int i = 1; i <= NF; i++) begin
                    int idx;
                    idx = (m_last + i) % NF;
                    if (!any && mq[idx].size() != 0) begin any = 1; g = idx; end
                end
            end
            check("pop_valid", pop_valid, any);
            if (any) begin
                check("pop_flow", pop_flow, g);
                check("pop_data", pop_data, mq[g][0]);
                check("rd_addr", ram_rd_addr, g * D + m_rd[g]);
            end
            if (any && pop_ready) begin
                void'(mq[g].pop_front());
                m_rd[g] = (m_rd[g] + 1) % D;
                m_last = g;
                m_locked = 0;
            end else begin
                m_locked = any;
                m_lock_flow = g;
            end
            for (int f = 0; f < NF; f++) begin
                m_cnt[f] += ((any && pop_ready && g == f) ? 1 : 0) - (e_cred[f] ? 1 : 0);
                if (e_cred[f]) snd_cred[f]++;
            end

            if (push_valid) begin
                fp = int'(push_flow);
                snd_cred[fp]--;
                if (mq[fp].size() == D) begin
`ifdef BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
                    check("ovf_no_write", ram_wr_valid, 0);
                    m_ovf[fp] = 1;
`endif
                end else begin
                    check("wr_valid", ram_wr_valid, 1);
                    check("wr_addr", ram_wr_addr, fp * D + m_wr[fp]);
                    mq[fp].push_back(push_data);
                    m_wr[fp] = (m_wr[fp] + 1) % D;
                end
            end
`ifdef BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
            check("overflow_err", overflow_err, {m_ovf[1], m_ovf[0]});
`endif
        end
    end

    // Scoreboard for u_dut3 (flow 0 only).
    logic [7:0] bq [$];
    int b_wr, b_rd, b_pulses;

    always @(negedge clk) begin : mon_b
        if (rst) begin
            bq.delete(); b_wr = 0; b_rd = 0; b_pulses = 0;
        end else begin
            if (b_push_credit[0]) b_pulses++;
            check("b_pop_valid", b_pop_valid, bq.size() != 0);
            if (b_pop_valid && b_pop_ready && bq.size() != 0) begin
                check("b_pop_flow", b_pop_flow, 0);
                check("b_pop_data", b_pop_data, bq[0]);
                check("b_rd_addr", b_rd_addr, b_rd);
                void'(bq.pop_front());
                b_rd = (b_rd + 1) % 3;
            end
            if (b_push_valid) begin
                check("b_wr_addr", b_wr_addr, b_wr);
                bq.push_back(b_push_data);
                b_wr = (b_wr + 1) % 3;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push1(input logic f, input logic [7:0] d);
        push_valid = 1'b1; push_flow = f; push_data = d;
        tick();
        push_valid = 1'b0;
    endtask

    int p0;

    initial begin
        idle(3);
        rst = 1'b0;
        idle(6);
        check("credits_drained", credit_count_push, 0);

        // One-cycle cut-through on flow 1.
        pop_ready = 1'b1;
        push1(1'b1, 8'hA5);
        idle(3);

        // Round-robin over two flows that each hold three entries.
        pop_ready = 1'b0;
        for (int i = 0; i < 3; i++) push1(1'b0, 8'h10 + 8'(i));
        for (int i = 0; i < 3; i++) push1(1'b1, 8'h20 + 8'(i));
        pop_ready = 1'b1;
        idle(8);
        check("rr_empty", empty, 2'b11);

        // A stalled grant holds while another flow becomes non-empty.
        pop_ready = 1'b0;
        push1(1'b1, 8'h33);
        idle(2);
        push1(1'b0, 8'h44);
        idle(3);
        pop_ready = 1'b1;
        idle(4);

        // Fill flow 0 completely.
        pop_ready = 1'b0;
        for (int i = 0; i < 4; i++) push1(1'b0, 8'h50 + 8'(i));
        idle(1);
        check("full0", full, 2'b01);
`ifdef BR_FIFO_MULTIFLOW_OVERFLOW_FLAG_EN
        push1(1'b0, 8'hEE);
        idle(1);
        check("ovf_flag0", overflow_err, 2'b01);
        check("ovf_items0", items[2:0], 4);
`endif
        pop_ready = 1'b1;
        idle(6);

        // Reset mid-operation discards queued entries.
        pop_ready = 1'b0;
        push1(1'b0, 8'h61);
        push1(1'b1, 8'h62);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        check("midrst_empty", empty, 2'b11);
        check("midrst_credit", push_credit, 2'b11);
        idle(6);

        // Random traffic: the sender respects the credits it has received.
        for (int c = 0; c < 400; c++) begin
            int f;
            pop_ready = ($urandom_range(0, 3) != 0);
            push_credit_stall = ($urandom_range(0, 7) == 0);
            if (c % 50 == 0)
                credit_withhold_push = {3'($urandom_range(0, 1)), 3'($urandom_range(0, 1))};
            f = int'($urandom_range(0, 1));
            if (snd_cred[f] > 0 && $urandom_range(0, 2) != 0) begin
                push_valid = 1'b1; push_flow = f[0]; push_data = 8'($urandom);
            end else begin
                push_valid = 1'b0;
            end
            tick();
        end
        push_valid = 1'b0; pop_ready = 1'b1; push_credit_stall = 1'b0;
        credit_withhold_push = '0;
        idle(20);
        check("rand_drained", empty, 2'b11);

        // Depth 3: seven entries wrap both pointers twice.
        b_pop_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b_push_valid = 1'b1; b_push_data = 8'h80 + 8'(i);
            tick();
        end
        b_push_valid = 1'b0;
        idle(4);
        check("b_credits", b_pulses, 7);
        check("b_empty", b_empty, 2'b11);
        check("b_ccount0", b_ccount, 0);

        // A credit stall holds released credits until it deasserts.
        p0 = b_pulses;
        b_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_push_valid = 1'b1; b_push_data = 8'hC0 + 8'(i);
            tick();
        end
        b_push_valid = 1'b0;
        idle(3);
        check("b_stall_hold", b_pulses - p0, 0);
        check("b_ccount3", b_ccount, 4'h3);
        b_stall = 1'b0;
        idle(5);
        check("b_release", b_pulses - p0, 3);
        check("b_ccount_end", b_ccount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
